// File: rtl/fas_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : fas_result_checker
// Purpose  : Compares beats of DUT results against golden results lane by
//            lane with a per-component tolerance, counts bad lanes and decides
//            PASS/FAIL for a run of EXPECT_CNT lane samples. A run aborts
//            early once FAIL_LIMIT lanes have been found in error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i         sole clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       one-cycle pulse that begins a run (ignored while running)
//   dut_valid_i   a beat of dut_data_i / gold_data_i is presented
//   dut_data_i    DUT results, lane 0 in the LSBs, real in upper DW of a lane
//   gold_data_i   expected results, same packing as dut_data_i
//   busy_o        run in progress
//   done_o        run finished (PASS or FAIL)
//   pass_o        run finished with no errors
//   err_valid_o   one-cycle pulse: the beat reported on err_idx_o had errors
//   err_idx_o     sample index of the lowest bad lane of that beat
//   err_cnt_o     lanes in error this run, saturating
//   sample_cnt_o  lane samples checked this run
// ============================================================================
module fas_result_checker #(
  parameter int LANES      = 16,
  parameter int DW         = 16,
  parameter int COMPLEX    = 1,
  parameter int TOL        = 3,
  parameter int FAIL_LIMIT = 48,
  parameter int EXPECT_CNT = 1024,
  localparam int LW        = DW * (COMPLEX + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                dut_valid_i,
  input  logic [LANES*LW-1:0] dut_data_i,
  input  logic [LANES*LW-1:0] gold_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                err_valid_o,
  output logic [15:0]         err_idx_o,
  output logic [15:0]         err_cnt_o,
  output logic [15:0]         sample_cnt_o
);

  localparam int NC = COMPLEX + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [16:0]      acc_q;          // one extra bit so acc_q + LANES never wraps
  logic             s1_vld_q;
  logic [LANES-1:0] s1_flags_q;
  logic [15:0]      s1_base_q;
  logic             err_valid_q;
  logic [15:0]      err_idx_q;
  logic [15:0]      err_cnt_q;
  logic [15:0]      sample_cnt_q;

  logic             w_start_go;
  logic             w_accept;
  logic [LANES-1:0] w_lane_bad;
  logic [DW-1:0]    w_diff;
  logic signed [31:0] w_d;
  logic [4:0]       w_pop;
  logic [15:0]      w_lo;
  logic [16:0]      w_err_sum;
  logic [15:0]      w_err_next;

  assign w_start_go = start_i && (state_q != S_RUN);
  assign w_accept   = (state_q == S_RUN) && dut_valid_i &&
                      ({15'd0, acc_q} < 32'(EXPECT_CNT));

  // Per-component difference taken modulo 2^DW and read as signed, so values
  // that straddle the wrap point (e.g. 0x0001 vs 0xFFFF) compare as close.
  always_comb begin
    w_lane_bad = '0;
    w_diff     = '0;
    w_d        = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < NC; c++) begin
        w_diff = dut_data_i[l*LW + c*DW +: DW] - gold_data_i[l*LW + c*DW +: DW];
        w_d    = {{(32-DW){w_diff[DW-1]}}, w_diff};
        if ((w_d > TOL) || (w_d < -TOL)) begin
          w_lane_bad[l] = 1'b1;
        end
      end
    end
  end

  // Stage-2 helpers: popcount of bad lanes and the lowest bad lane number.
  always_comb begin
    w_pop = '0;
    w_lo  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop = w_pop + {4'd0, s1_flags_q[l]};
    end
    for (int l = LANES - 1; l >= 0; l--) begin
      if (s1_flags_q[l]) begin
        w_lo = 16'(l);
      end
    end
    w_err_sum  = {1'b0, err_cnt_q} + {12'd0, w_pop};
    w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  // Decisions use the registered counters, so the state changes on the edge
  // after stage 2 has updated them. Abort is checked first so FAIL wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if ({16'd0, err_cnt_q} >= 32'(FAIL_LIMIT)) begin
          state_d = S_FAIL;
        end else if ({16'd0, sample_cnt_q} >= 32'(EXPECT_CNT)) begin
          state_d = (err_cnt_q == 16'd0) ? S_PASS : S_FAIL;
        end
      end
      S_PASS: if (start_i) state_d = S_RUN;
      S_FAIL: if (start_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_flags_q   <= '0;
      s1_base_q    <= '0;
      err_valid_q  <= 1'b0;
      err_idx_q    <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      err_valid_q <= 1'b0;
      if (w_start_go) begin
        acc_q        <= '0;
        err_cnt_q    <= '0;
        sample_cnt_q <= '0;
        s1_vld_q     <= 1'b0;
      end else begin
        // Stage 1: capture flags and base index of an accepted beat.
        s1_vld_q <= w_accept;
        if (w_accept) begin
          s1_flags_q <= w_lane_bad;
          s1_base_q  <= acc_q[15:0];
          acc_q      <= acc_q + 17'(LANES);
        end
        // Stage 2 drains regardless of state so an in-flight beat still
        // counts after an early abort.
        if (s1_vld_q) begin
          err_cnt_q    <= w_err_next;
          sample_cnt_q <= sample_cnt_q + 16'(LANES);
          if (|s1_flags_q) begin
            err_valid_q <= 1'b1;
            err_idx_q   <= s1_base_q + w_lo;
          end
        end
      end
    end
  end

  assign busy_o       = (state_q == S_RUN);
  assign done_o       = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass_o       = (state_q == S_PASS);
  assign err_valid_o  = err_valid_q;
  assign err_idx_o    = err_idx_q;
  assign err_cnt_o    = err_cnt_q;
  assign sample_cnt_o = sample_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fas_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fas_result_checker
// Purpose  : Self-checking bench for fas_result_checker. Instance A uses the
//            default parameters, instance B is a single real lane with TOL=0.
//            Expected error reports are queued when beats are issued and a
//            monitor pops them whenever a DUT pulses err_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fas_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: LANES=16, COMPLEX=1, TOL=3
  logic         a_start, a_valid;
  logic [511:0] a_dut, a_gold;
  logic         a_busy, a_done, a_pass, a_err_valid;
  logic [15:0]  a_err_idx, a_err_cnt, a_sample_cnt;

  // Instance B: LANES=1, COMPLEX=0, TOL=0
  logic         b_start, b_valid;
  logic [15:0]  b_dut, b_gold;
  logic         b_busy, b_done, b_pass, b_err_valid;
  logic [15:0]  b_err_idx, b_err_cnt, b_sample_cnt;

  fas_result_checker u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .dut_valid_i(a_valid),
    .dut_data_i(a_dut), .gold_data_i(a_gold),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
    .err_valid_o(a_err_valid), .err_idx_o(a_err_idx),
    .err_cnt_o(a_err_cnt), .sample_cnt_o(a_sample_cnt)
  );

  fas_result_checker #(.LANES(1), .DW(16), .COMPLEX(0), .TOL(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .dut_valid_i(b_valid),
    .dut_data_i(b_dut), .gold_data_i(b_gold),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
    .err_valid_o(b_err_valid), .err_idx_o(b_err_idx),
    .err_cnt_o(b_err_cnt), .sample_cnt_o(b_sample_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int qa[$];
  int qb[$];
  int a_acc;   // model of instance A accept counter
  bit a_live;  // model: instance A is in a run and accepting

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every err_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (a_err_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_err_unexpected: err_idx=%0d, expected no pulse", a_err_idx);
      end else begin
        chk("a_err_idx", 32'(a_err_idx), 32'(qa.pop_front()));
      end
    end
    if (b_err_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_err_unexpected: err_idx=%0d, expected no pulse", b_err_idx);
      end else begin
        chk("b_err_idx", 32'(b_err_idx), 32'(qb.pop_front()));
      end
    end
  end

  // kind 0: offsets in -3..+3; 1: 0001 vs FFFF (+2); 2: 7FFF vs 8000 (-1);
  // 3: every component +4; 4: clean except beat 3 lane 5 imag -4 and
  // lane 9 real +4; 5: clean for beats < 64, +4 afterwards.
  task automatic a_beat(input int kind, input int b);
    logic [15:0] g, d;
    int off, lo;
    lo = -1;
    for (int l = 0; l < 16; l++) begin
      for (int c = 0; c < 2; c++) begin
        g   = 16'($urandom);
        off = ((b * 16 + l + c) % 7) - 3;
        if (kind == 3 || (kind == 5 && b >= 64)) off = 4;
        if (kind == 4 && b == 3 && l == 5 && c == 0) off = -4;
        if (kind == 4 && b == 3 && l == 9 && c == 1) off = 4;
        d = g + 16'(off);
        if (kind == 1) begin g = 16'hFFFF; d = 16'h0001; off = 2;  end
        if (kind == 2) begin g = 16'h8000; d = 16'h7FFF; off = -1; end
        a_gold[l*32 + c*16 +: 16] = g;
        a_dut [l*32 + c*16 +: 16] = d;
        if ((off > 3 || off < -3) && lo < 0) lo = l;
      end
    end
    if (a_live && a_acc < 1024) begin
      if (lo >= 0) qa.push_back(a_acc + lo);
      a_acc += 16;
    end
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic a_go();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_live = 1'b1;
    a_acc  = 0;
  endtask

  // Counts edges from now until done is seen, bounded.
  task automatic a_wait_done(output int cyc);
    cyc = 0;
    while (a_done !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    a_live = 1'b0;
  endtask

  task automatic a_check_end(input string tag, input logic exp_pass,
                             input int exp_err, input int exp_smp);
    chk({tag, "_done"},   32'(a_done), 32'd1);
    chk({tag, "_pass"},   32'(a_pass), 32'(exp_pass));
    chk({tag, "_busy"},   32'(a_busy), 32'd0);
    chk({tag, "_errcnt"}, 32'(a_err_cnt), 32'(exp_err));
    chk({tag, "_smpcnt"}, 32'(a_sample_cnt), 32'(exp_smp));
    chk({tag, "_errq_left"}, 32'(qa.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    a_start = 0; a_valid = 0; a_dut = '0; a_gold = '0;
    b_start = 0; b_valid = 0; b_dut = '0; b_gold = '0;
    a_live = 0; a_acc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_busy", 32'(a_busy), 0);   chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_pass", 32'(a_pass), 0);   chk("rst_a_errv", 32'(a_err_valid), 0);
    chk("rst_a_errcnt", 32'(a_err_cnt), 0); chk("rst_a_smp", 32'(a_sample_cnt), 0);
    chk("rst_b_done", 32'(b_done), 0);   chk("rst_b_smp", 32'(b_sample_cnt), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single real lane, TOL=0, sample 37 off by +1.
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    for (int s = 0; s < 1024; s++) begin
      b_gold = 16'($urandom);
      b_dut  = b_gold + ((s == 37) ? 16'd1 : 16'd0);
      if (s == 37) qb.push_back(37);
      b_valid = 1'b1; @(posedge clk); #1; b_valid = 1'b0;
    end
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("b_done", 32'(b_done), 1);     chk("b_pass", 32'(b_pass), 0);
    chk("b_errcnt", 32'(b_err_cnt), 1); chk("b_smpcnt", 32'(b_sample_cnt), 1024);
    chk("b_errq_left", 32'(qb.size()), 0);

    // Clean run within tolerance; done two edges after the last accept.
    a_go();
    for (int b = 0; b < 64; b++) a_beat(0, b);
    a_wait_done(cyc);
    chk("a_pass_latency", 32'(cyc), 2);
    a_check_end("clean", 1'b1, 0, 1024);

    // Wrap-around differences.
    a_go();
    for (int b = 0; b < 64; b++) a_beat(1, b);
    a_wait_done(cyc);
    a_check_end("wrap_p2", 1'b1, 0, 1024);
    a_go();
    for (int b = 0; b < 64; b++) a_beat(2, b);
    a_wait_done(cyc);
    a_check_end("wrap_m1", 1'b1, 0, 1024);

    // Just outside tolerance in two lanes of beat 3: idx 3*16+5 = 53.
    a_go();
    for (int b = 0; b < 64; b++) a_beat(4, b);
    a_wait_done(cyc);
    a_check_end("tol_edge", 1'b0, 2, 1024);
    chk("tol_edge_idx", 32'(a_err_idx), 53);

    // Early abort: 16, 32, 48 errors; FAIL two edges after beat 2.
    a_go();
    for (int b = 0; b < 3; b++) a_beat(3, b);
    a_wait_done(cyc);
    chk("abort_latency", 32'(cyc), 2);
    a_check_end("abort", 1'b0, 48, 48);
    for (int b = 3; b < 13; b++) a_beat(3, b);
    chk("abort_ignored_smp", 32'(a_sample_cnt), 48);
    chk("abort_ignored_err", 32'(a_err_cnt), 48);
    chk("abort_hold_idx", 32'(a_err_idx), 32);

    // Reset mid-run, then no acceptance before start, then a clean run.
    a_go();
    for (int b = 0; b < 10; b++) a_beat(0, b);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(a_busy), 0);  chk("midrst_done", 32'(a_done), 0);
    chk("midrst_pass", 32'(a_pass), 0);  chk("midrst_errv", 32'(a_err_valid), 0);
    chk("midrst_errcnt", 32'(a_err_cnt), 0); chk("midrst_smp", 32'(a_sample_cnt), 0);
    chk("midrst_idx", 32'(a_err_idx), 0);
    a_live = 1'b0; qa.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) a_beat(3, b);
    repeat (3) @(posedge clk); #1;
    chk("nostart_smp", 32'(a_sample_cnt), 0);
    chk("nostart_busy", 32'(a_busy), 0);
    a_go();
    for (int b = 0; b < 64; b++) a_beat(0, b);
    a_wait_done(cyc);
    a_check_end("after_rst", 1'b1, 0, 1024);

    // start during RUN is ignored; beats 64..69 (bad) must not be counted.
    a_go();
    for (int b = 0; b < 70; b++) begin
      if (b == 5) a_start = 1'b1;
      a_beat(5, b);
      a_start = 1'b0;
    end
    a_wait_done(cyc);
    a_check_end("restart_ign", 1'b1, 0, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
